systolic_array_driver: RTL

- Initiator-side sequencer for the weight-stationary systolic array; it drives the array's weight-load, start and input ports and consumes its done flag.
- Accepts a row-major weight matrix and then a batch of input vectors over valid/ready streams.
- Writes the weights into the array one per cycle, pulses start, and feeds the vectors with the diagonal skew the array expects.
- Flushes the skew with zeros, waits for the array's done flag, then reports batch completion.

---
 rtl/systolic_array_driver_if.sv | 37 +++
 rtl/systolic_array_driver.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/systolic_array_driver_if.sv
// Signal bundle between the systolic array driver, its weight/vector source and the array.
// The slave modport is the driver; the master modport is everything around it.
`timescale 1ns/1ps
interface systolic_array_driver_if #(
   parameter int SIZE       = 3,
   parameter int DATA_WIDTH = 16
);
   localparam int ADDR_WIDTH = $clog2(SIZE * SIZE);

   logic                       w_valid;
   logic                       w_ready;
   logic [DATA_WIDTH-1:0]      w_data;
   logic                       x_valid;
   logic                       x_ready;
   logic [SIZE*DATA_WIDTH-1:0] x_data;
   logic                       x_last;
   logic                       arr_load_weights;
   logic [DATA_WIDTH-1:0]      arr_weight_data;
   logic [ADDR_WIDTH-1:0]      arr_weight_mem;
   logic                       arr_start;
   logic [SIZE*DATA_WIDTH-1:0] arr_input_data;
   logic                       arr_done;
   logic                       busy;
   logic                       batch_done;

   modport slave (
      input  w_valid, w_data, x_valid, x_data, x_last, arr_done,
      output w_ready, x_ready, arr_load_weights, arr_weight_data, arr_weight_mem,
             arr_start, arr_input_data, busy, batch_done
   );

   modport master (
      output w_valid, w_data, x_valid, x_data, x_last, arr_done,
      input  w_ready, x_ready, arr_load_weights, arr_weight_data, arr_weight_mem,
             arr_start, arr_input_data, busy, batch_done
   );
endinterface

// File: rtl/systolic_array_driver.sv
// Sequencer for a weight-stationary systolic array: loads SIZE*SIZE weights,
// pulses start, streams skewed input vectors, drains the skew with zeros and
// waits for the array's done flag before reporting batch completion.
// SIZE must be at least 2.
`timescale 1ns/1ps
module systolic_array_driver #(
   parameter int SIZE       = 3,
   parameter int DATA_WIDTH = 16
) (
   input logic                    clk,
   input logic                    reset_n,
   systolic_array_driver_if.slave bus
);
   localparam int ADDR_WIDTH  = $clog2(SIZE * SIZE);
   localparam int CNT_WIDTH   = ADDR_WIDTH + 1;
   localparam int DRAIN_LEN   = (SIZE - 1 > 2) ? SIZE - 1 : 2;
   localparam int DRAIN_WIDTH = $clog2(DRAIN_LEN);
   localparam logic [CNT_WIDTH-1:0]   W_LAST     = CNT_WIDTH'(SIZE * SIZE - 1);
   localparam logic [DRAIN_WIDTH-1:0] DRAIN_LAST = DRAIN_WIDTH'(DRAIN_LEN - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      STREAM,
      DRAIN,
      WAIT_DONE
   } state_t;

   state_t                     state, state_next;
   logic [CNT_WIDTH-1:0]       w_cnt, w_cnt_next;
   logic [DRAIN_WIDTH-1:0]     drain_cnt, drain_cnt_next;
   logic                       w_accept, x_accept;
   logic                       start_next, done_next;
   logic                       w_ready_q, x_ready_q;
   logic                       load_q, start_q, done_q;
   logic [DATA_WIDTH-1:0]      weight_q;
   logic [ADDR_WIDTH-1:0]      addr_q;
   logic [SIZE*DATA_WIDTH-1:0] lane_out;

   // State register plus the weight and drain counters it owns.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         w_cnt     <= '0;
         drain_cnt <= '0;
      end else begin
         state     <= state_next;
         w_cnt     <= w_cnt_next;
         drain_cnt <= drain_cnt_next;
      end
   end

   // Next-state decode; the ready registers gate acceptance, so a handshake only
   // counts in the state that owns that stream.
   always_comb begin
      state_next     = state;
      w_cnt_next     = w_cnt;
      drain_cnt_next = drain_cnt;
      w_accept       = 1'b0;
      x_accept       = 1'b0;
      start_next     = 1'b0;
      done_next      = 1'b0;
      case (state)
         IDLE: begin
            w_accept = bus.w_valid && w_ready_q;
            if (w_accept) begin
               if (w_cnt == W_LAST) begin
                  state_next = START;
                  w_cnt_next = '0;
                  start_next = 1'b1;
               end else begin
                  w_cnt_next = w_cnt + 1'b1;
               end
            end
         end
         START: begin
            state_next = STREAM;
         end
         STREAM: begin
            x_accept = bus.x_valid && x_ready_q;
            if (x_accept && bus.x_last) begin
               state_next     = DRAIN;
               drain_cnt_next = '0;
            end
         end
         DRAIN: begin
            if (drain_cnt == DRAIN_LAST) begin
               state_next     = WAIT_DONE;
               drain_cnt_next = '0;
            end else begin
               drain_cnt_next = drain_cnt + 1'b1;
            end
         end
         WAIT_DONE: begin
            if (bus.arr_done) begin
               done_next  = 1'b1;
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Registered outputs; readies come from the upcoming state so they are low in reset.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         w_ready_q <= 1'b0;
         x_ready_q <= 1'b0;
         load_q    <= 1'b0;
         start_q   <= 1'b0;
         done_q    <= 1'b0;
         weight_q  <= '0;
         addr_q    <= '0;
      end else begin
         w_ready_q <= (state_next == IDLE);
         x_ready_q <= (state_next == STREAM);
         load_q    <= w_accept;
         start_q   <= start_next;
         done_q    <= done_next;
         if (w_accept) begin
            weight_q <= bus.w_data;
            addr_q   <= w_cnt[ADDR_WIDTH-1:0];
         end
      end
   end

   // Lane i passes through i+1 registers, giving the diagonal skew; bubbles shift in zeros.
   for (genvar i = 0; i < SIZE; i++) begin : g_lane
      logic [DATA_WIDTH-1:0] pipe [0:i];

      // Per-lane delay line fed by the accepted vector or zero.
      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            for (int j = 0; j <= i; j++) pipe[j] <= '0;
         end else begin
            pipe[0] <= x_accept ? bus.x_data[i*DATA_WIDTH +: DATA_WIDTH] : '0;
            for (int j = 1; j <= i; j++) pipe[j] <= pipe[j-1];
         end
      end

      assign lane_out[i*DATA_WIDTH +: DATA_WIDTH] = pipe[i];
   end

   assign bus.w_ready          = w_ready_q;
   assign bus.x_ready          = x_ready_q;
   assign bus.arr_load_weights = load_q;
   assign bus.arr_weight_data  = weight_q;
   assign bus.arr_weight_mem   = addr_q;
   assign bus.arr_start        = start_q;
   assign bus.batch_done       = done_q;
   assign bus.arr_input_data   = lane_out;
   assign bus.busy             = (state != IDLE) || (w_cnt != '0);
endmodule
